// File: rtl/jtframe_dcins.sv
// DC re-insertion for the audio path: signed din becomes unsigned dout centred on midscale, with a slow anti-pop offset ramp.
// Outputs register one clock after each sample strobe; there is no backpressure, only the strobe advances the stage.
module jtframe_dcins #(
  parameter int SW = 8,
  parameter int RS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample,
  input  logic          mute,
  input  logic [SW-1:0] din,
  output logic [SW-1:0] dout,
  output logic          ready
);

  localparam int OW = SW + RS;
  localparam logic [OW-1:0] MID  = {1'b1, {(OW-1){1'b0}}};
  localparam logic [OW-1:0] ONE  = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    RUN,
    DOWN
  } state_t;

  state_t        st, st_nx;
  logic [OW-1:0] ofs, ofs_nx;
  logic [SW-1:0] dout_nx;

  always_comb begin
    st_nx   = st;
    ofs_nx  = ofs;
    dout_nx = dout;
    if (sample) begin
      case (st)
        IDLE: if (!mute) begin
          st_nx  = UP;
          ofs_nx = ONE;
        end
        UP: if (mute) begin
          st_nx  = DOWN;
          ofs_nx = ofs - ONE;
        end else begin
          ofs_nx = ofs + ONE;
        end
        RUN: if (mute) begin
          st_nx  = DOWN;
          ofs_nx = MID - ONE;
        end
        DOWN: if (!mute) begin
          st_nx  = UP;
          ofs_nx = ofs + ONE;
        end else begin
          ofs_nx = ofs - ONE;
        end
        default: st_nx = IDLE;
      endcase
      // A ramp ends the moment the offset lands on either rail, whichever direction got it there.
      if (st_nx == UP && ofs_nx == MID) st_nx = RUN;
      if (st_nx == DOWN && ofs_nx == ZERO) st_nx = IDLE;

      case (st_nx)
        IDLE:    dout_nx = '0;
        RUN:     dout_nx = {~din[SW-1], din[SW-2:0]};
        default: dout_nx = ofs_nx[OW-1:RS];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      ofs   <= '0;
      dout  <= '0;
      ready <= 1'b0;
    end else if (sample) begin
      st    <= st_nx;
      ofs   <= ofs_nx;
      dout  <= dout_nx;
      ready <= (st_nx == RUN);
    end
  end

endmodule

// File: tb/tb_jtframe_dcins.sv
// Scoreboard bench for jtframe_dcins: stimulus pushes expected dout/ready per strobe, a monitor pops and compares.
module tb_jtframe_dcins;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample = 1'b0;
  logic       mute = 1'b0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic       ready;

  jtframe_dcins #(.SW(8), .RS(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .sample (sample),
    .mute   (mute),
    .din    (din),
    .dout   (dout),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       r;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       strobe_d = 1'b0;
  logic       have = 1'b0;
  logic [7:0] exp_d = 8'd0;
  logic       exp_r = 1'b0;
  int         gap = 3;

  always @(posedge clk) strobe_d <= sample | rst;

  // Between strobes the outputs must hold the last expected value.
  always @(negedge clk) begin
    exp_t e;
    if (strobe_d) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL underflow: dout=%0d ready=%0d with no expected entry", dout, ready);
      end else begin
        e = sb.pop_front();
        exp_d = e.d;
        exp_r = e.r;
        have  = 1'b1;
        if (dout !== e.d || ready !== e.r) begin
          n_bad++;
          $display("FAIL %s: dout=%0d ready=%0d expected dout=%0d ready=%0d",
                   e.tag, dout, ready, e.d, e.r);
        end
      end
    end else if (have) begin
      n_cmp++;
      if (dout !== exp_d || ready !== exp_r) begin
        n_bad++;
        $display("FAIL hold: dout=%0d ready=%0d expected dout=%0d ready=%0d",
                 dout, ready, exp_d, exp_r);
      end
    end
  end

  task automatic push(input logic [7:0] ed, input logic er, input string tag);
    exp_t e;
    e.d = ed;
    e.r = er;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Idle clocks scramble din and mute; neither may leak through without a strobe.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din  = 8'($urandom_range(0, 255));
      mute = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic smp(input logic m, input logic [7:0] d, input logic [7:0] ed,
                     input logic er, input string tag);
    mute   = m;
    din    = d;
    sample = 1'b1;
    push(ed, er, tag);
    @(posedge clk);
    #1;
    sample = 1'b0;
    idle(gap);
  endtask

  task automatic reset_clk(input logic with_sample, input logic [7:0] d);
    rst    = 1'b1;
    sample = with_sample;
    din    = d;
    mute   = 1'b0;
    push(8'd0, 1'b0, "reset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    sample = 1'b0;
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    @(posedge clk);
    #1;
    // 1: power-up ramp, one strobe every 4 clocks
    reset_clk(1'b0, 8'd0);
    reset_clk(1'b0, 8'd0);
    idle(3);
    for (int k = 1; k <= 512; k++)
      smp(1'b0, 8'd0, (k == 512) ? 8'd128 : 8'(k >> 2), (k == 512), "rampup");

    // 2: RUN mapping, plus gating while in RUN
    smp(1'b0, 8'h80, 8'd0,   1'b1, "run_m128");
    smp(1'b0, 8'h7f, 8'd255, 1'b1, "run_127");
    smp(1'b0, 8'h05, 8'd133, 1'b1, "run_5");
    smp(1'b0, 8'hff, 8'd127, 1'b1, "run_m1");
    idle(100);

    // 3: mute ramp-down, gating in DOWN midway and in IDLE at the end
    for (int k = 1; k <= 512; k++) begin
      smp(1'b1, rnd(), 8'((512 - k) >> 2), 1'b0, (k == 1) ? "down_first" : "rampdown");
      if (k == 300) idle(100);
    end
    for (int k = 0; k < 3; k++) smp(1'b1, rnd(), 8'd0, 1'b0, "idle_muted");
    idle(100);

    // 4: reversal at ofs=200
    for (int k = 1; k <= 200; k++) smp(1'b0, rnd(), 8'(k >> 2), 1'b0, "up_to200");
    idle(100);
    for (int j = 1; j <= 8; j++) smp(1'b1, rnd(), 8'((200 - j) >> 2), 1'b0, "rev_down");
    for (int j = 1; j <= 320; j++)
      smp(1'b0, (j == 320) ? 8'd0 : rnd(), (j == 320) ? 8'd128 : 8'((192 + j) >> 2),
          (j == 320), "rev_up");

    // 5: reset overrides a same-clock strobe in RUN
    smp(1'b0, 8'd100, 8'd228, 1'b1, "run_100");
    reset_clk(1'b1, 8'd100);
    idle(3);
    for (int k = 1; k <= 4; k++) smp(1'b0, rnd(), 8'(k >> 2), 1'b0, "restart");

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
